div: RTL and testbench
======================

# div

Multi-cycle 32-bit serial divider, signed and unsigned, serving the execute stage. The execute stage raises `start_i` with latched operands and stalls the pipeline until `ready_o` returns; it then writes `result_o` into HI/LO. The core is a radix-2 restoring divider: one quotient bit per cycle, one 32-bit subtractor, no combinational divide.

## Interface
- No parameters. Width is fixed at 32-bit operands and a 64-bit result.
- `clk`  in  1  — single clock. All state changes on the rising edge.
- `rst`  in  1  — synchronous, active-high reset (`RstEnable` = 1).
- `signed_div_i`  in  1  — 1 selects signed (two's complement) division; 0 selects unsigned. Sampled only when a start is accepted.
- `opdata1_i`  in  32  — dividend. Sampled only when a start is accepted.
- `opdata2_i`  in  32  — divisor. Sampled only when a start is accepted.
- `start_i`  in  1  — request/hold (`DivStart` = 1). Held high by the execute stage until it sees `ready_o`.
- `annul_i`  in  1  — abort request. Honoured only in `ON`.
- `result_o`  out  64  — `{remainder, quotient}`; bits [63:32] go to HI and bits [31:0] go to LO.
- `ready_o`  out  1  — `DivResReady` = 1 when `result_o` is valid.

## Operation
- States: `FREE`, `BYZERO`, `ON`, `END`. The state is held in registers.
- `FREE`:
  - If `start_i=1` and `annul_i=0`, latch `signed_div_i` and the operands.
  - If `opdata2_i == 0`, next state is `BYZERO`.
  - Otherwise, next state is `ON`:
    - Load the working register `dividend[64:0] = {32'b0, |op1|, 1'b0}`, where |x| is the two's-complement magnitude if signed and x[31]=1, else x.
    - Store the divisor as |op2|.
    - Clear `cnt[5:0]`.
  - Otherwise stay in `FREE`.
- `BYZERO`:
  - Set the working result to 0.
  - Go to `END`.
- `ON` — each cycle, if `annul_i=0`:
  - Compute `diff = {1'b0, dividend[63:32]} - {1'b0, divisor}`.
  - If `diff[32]` (borrow), shift `dividend` left by 1.
  - Else, load `dividend = {diff[31:0], dividend[31:0], 1'b1}`.
  - Increment `cnt`.
  - When `cnt == 32`, apply sign fix-up and go to `END`:
    - Signed with op1[31]^op2[31]: quotient = two's complement of `dividend[31:0]`.
    - Signed with op1[31]=1: remainder = two's complement of `dividend[64:33]`.
    - Otherwise the values are unsigned.
    - Latch `{remainder, quotient}` into `result_o`.
  - `annul_i=1` in `ON` → `FREE` with no result. `ready_o` stays 0.
- `END`:
  - Assert `ready_o=1` and hold `result_o`.
  - Stay while `start_i=1`.
  - When `start_i=0`, go to `FREE`; in that transition cycle clear `result_o` to 0 and `ready_o` to 0.
- Arithmetic rules:
  - Magnitudes of 0x80000000 wrap naturally: |0x80000000| = 0x80000000, treated as unsigned.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. No trap, no flag.
- Operand changes after acceptance are ignored. `signed_div_i` is not re-sampled after acceptance.

## Timing
- Reset values: state `FREE`, `ready_o=0`, `result_o=64'h0`, `cnt=0`, working registers 0.
- Reset asserted in any state, including mid-`ON` or in `END`, takes effect at the next edge.
- Normal divide latency:
  - Start is seen in `FREE` at edge 0.
  - `ON` occupies edges 1–32.
  - `ready_o=1` is visible from edge 33 onward.
  - That is 33 cycles from start to ready.
- Divide by zero:
  - `ready_o=1` from edge 2.
  - `result_o=0`.
- `ready_o` stays high as long as `start_i` stays high. It drops in the cycle after `start_i` falls.
- A new start may be accepted on the first cycle back in `FREE`. There is no back-to-back acceptance from `END`.
- `annul_i` and `start_i` both high in `FREE`: no start is accepted.
- `annul_i` in `END` or `BYZERO` is ignored.

## Test plan
- Unsigned 100 / 7, start held → `ready_o` rises exactly 33 cycles after start; `result_o = 64'h00000002_0000000E`; `ready_o` drops one cycle after `start_i` falls.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → `result_o = 64'hFFFFFFFF_FFFFFFFD`. Also run unsigned 0xFFFFFFF9 / 2 → `result_o = 64'h00000001_7FFFFFFC`.
- Divisor 0 with dividend 0x12345678 → `ready_o` high 2 cycles after start; `result_o = 0`.
- Signed 0x80000000 / 0xFFFFFFFF → `result_o = 64'h00000000_80000000` at cycle 33.
- Annul at cycle 10 of `ON` → next state `FREE` with `ready_o` never asserted. A following start of 9/3 → `result_o = 64'h00000000_00000003` 33 cycles later.
- `rst` pulsed at cycle 20 of `ON`, and again while in `END` → all outputs 0 next edge; operand changes during `ON` do not alter the result.

Source files
------------

// File: rtl/div_if.sv
// Handshake and operand bundle between the execute stage (master) and the
// serial divider (slave).
interface div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div.sv
// Radix-2 restoring divider, 32-bit signed/unsigned, one quotient bit per
// cycle. Result is {remainder, quotient}, held until start drops.
module div (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    logic [1:0]  state;
    logic [64:0] dividend;
    logic [31:0] divisor;
    logic [5:0]  cnt;
    logic        neg_q;
    logic        neg_r;
    logic [63:0] work;

    logic [31:0] mag1, mag2;
    logic [32:0] diff;
    logic [64:0] next_div;
    logic [31:0] quo, rem;

    always_comb begin
        mag1 = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
        mag2 = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
        diff = {1'b0, dividend[63:32]} - {1'b0, divisor};
        // Borrow means the trial subtraction fails: restore by shifting only.
        next_div = diff[32] ? {dividend[63:0], 1'b0}
                            : {diff[31:0], dividend[31:0], 1'b1};
        quo = neg_q ? (~next_div[31:0] + 32'd1)  : next_div[31:0];
        rem = neg_r ? (~next_div[64:33] + 32'd1) : next_div[64:33];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_FREE;
            dividend     <= '0;
            divisor      <= '0;
            cnt          <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            work         <= '0;
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
        end else begin
            case (state)
                S_FREE: begin
                    if (bus.start_i && !bus.annul_i) begin
                        neg_q <= bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                        neg_r <= bus.signed_div_i & bus.opdata1_i[31];
                        if (bus.opdata2_i == 32'd0) begin
                            state <= S_BYZERO;
                        end else begin
                            state    <= S_ON;
                            dividend <= {32'b0, mag1, 1'b0};
                            divisor  <= mag2;
                            cnt      <= '0;
                        end
                    end
                end
                S_BYZERO: begin
                    work  <= '0;
                    state <= S_END;
                end
                S_ON: begin
                    if (bus.annul_i) begin
                        state <= S_FREE;
                    end else begin
                        dividend <= next_div;
                        cnt      <= cnt + 6'd1;
                        // Last quotient bit lands this edge; fix signs on the fly.
                        if (cnt == 6'd31) begin
                            work  <= {rem, quo};
                            state <= S_END;
                        end
                    end
                end
                default: begin
                    if (bus.start_i) begin
                        bus.ready_o  <= 1'b1;
                        bus.result_o <= work;
                    end else begin
                        state        <= S_FREE;
                        bus.ready_o  <= 1'b0;
                        bus.result_o <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div.sv
// Directed + random bench for the serial divider against an arithmetic model.
module tb_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    div_if bus();

    div dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
        return res;
    endfunction

    // Assumes start is already driven; counts edges after acceptance until ready.
    task automatic wait_ready(input bit scramble, output int lat);
        lat = -1;
        do begin
            @(posedge clk); #1;
            lat++;
            if (scramble) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = $urandom_range(0, 1);
            end
        end while (!bus.ready_o && lat < 100);
    endtask

    task automatic run(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
        int lat;
        @(negedge clk);
        bus.signed_div_i = s; bus.opdata1_i = a; bus.opdata2_i = b; bus.start_i = 1'b1;
        wait_ready(1'b1, lat);
        check({tag, "_lat"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
        check({tag, "_res"}, bus.result_o, model(s, a, b));
        repeat (hold) @(posedge clk);
        #1;
        if (hold > 0) check({tag, "_hold"}, {bus.ready_o, bus.result_o}, {1'b1, model(s, a, b)});
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        check({tag, "_drop"}, {bus.ready_o, bus.result_o}, 65'd0);
    endtask

    initial begin
        int lat, seen;
        bit s;
        logic [31:0] a, b;
        bus.signed_div_i = 1'b0; bus.opdata1_i = '0; bus.opdata2_i = '0;
        bus.start_i = 1'b0; bus.annul_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", {bus.ready_o, bus.result_o}, 65'd0);
        @(negedge clk); rst = 1'b0;

        run("u100_7", 1'b0, 32'd100, 32'd7, 3);
        check("u100_7_const", model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        run("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 0);
        run("u_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, 1);
        run("byzero", 1'b0, 32'h12345678, 32'd0, 2);
        run("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
        run("u_min_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 0);
        run("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 0);

        // Annul after 10 cycles in ON: no result ever appears.
        @(negedge clk);
        bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd123; bus.opdata2_i = 32'd4; bus.start_i = 1'b1;
        repeat (11) @(negedge clk);
        bus.annul_i = 1'b1;
        @(negedge clk);
        bus.annul_i = 1'b0; bus.start_i = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.ready_o) seen++; end
        check("annul_noready", 64'(seen), 64'd0);
        run("after_annul", 1'b0, 32'd9, 32'd3, 0);

        // annul held with start in FREE blocks acceptance.
        @(negedge clk);
        bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd5;
        bus.start_i = 1'b1; bus.annul_i = 1'b1;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.ready_o) seen++; end
        check("annul_free_block", 64'(seen), 64'd0);
        @(negedge clk); bus.annul_i = 1'b0;
        wait_ready(1'b0, lat);
        check("annul_free_lat", 64'(lat), 64'd33);
        check("annul_free_res", bus.result_o, 64'd10);
        // Reset while in END clears outputs at the next edge.
        @(negedge clk); rst = 1'b1; bus.start_i = 1'b0;
        @(posedge clk); #1;
        check("rst_end", {bus.ready_o, bus.result_o}, 65'd0);
        @(negedge clk); rst = 1'b0;

        // Reset mid-ON, then confirm a clean divide still works.
        @(negedge clk);
        bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3; bus.start_i = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b1; bus.start_i = 1'b0;
        @(posedge clk); #1;
        check("rst_on", {bus.ready_o, bus.result_o}, 65'd0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.ready_o) seen++; end
        check("rst_on_idle", 64'(seen), 64'd0);
        run("post_rst", 1'b1, 32'hFFFFFC18, 32'd3, 0);

        for (int i = 0; i < 20; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'($urandom_range(1, 15));
                1: b = -32'($urandom_range(1, 15));
                2: b = (i % 7 == 0) ? 32'd0 : $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run($sformatf("rnd%0d", i), s, a, b, 32'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
